// File: rtl/sram_bank_pkg.sv
// Shared defaults and master identifiers for the two-master SRAM bank arbiter.
package sram_bank_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 32;
    localparam int BW_DEF = DW_DEF / 8;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

endpackage

// File: rtl/sram_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2
    import sram_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    master_id_e last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == M1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = M0;
        end else if (gnt_o[1]) begin
            last_d = M1;
        end
    end

    // Reset to "m1 last" so m0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Two masters sharing one single-port SRAM macro; fixed one-cycle response latency.
module sram_bank_arbiter
    import sram_bank_pkg::*;
#(
    parameter  int AW = AW_DEF,
    parameter  int DW = DW_DEF,
    localparam int BW = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req_i,
    output logic          m0_gnt_o,
    input  logic [AW+1:0] m0_addr_i,
    input  logic          m0_we_i,
    input  logic [BW-1:0] m0_be_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,

    input  logic          m1_req_i,
    output logic          m1_gnt_o,
    input  logic [AW+1:0] m1_addr_i,
    input  logic          m1_we_i,
    input  logic [BW-1:0] m1_be_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic          sram_en_o,
    output logic          sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [BW-1:0] sram_be_o,
    output logic [DW-1:0] sram_wdata_o,
    input  logic [DW-1:0] sram_rdata_i
);

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          rsp_vld_q, rsp_vld_d;
    logic          rsp_rd_q, rsp_rd_d;
    master_id_e    rsp_id_q, rsp_id_d;
    logic [DW-1:0] hold0_q, hold0_d;
    logic [DW-1:0] hold1_q, hold1_d;
    logic          unused_addr_lsbs;

    // Word-aligned macro: byte offset bits carry no meaning.
    assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

    // Requests are masked while reset is held so no grant can escape.
    assign req = {m1_req_i, m0_req_i} & {2{rst_n}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = '0;
        sram_wdata_o = '0;
        if (gnt[0]) begin
            sram_en_o    = 1'b1;
            sram_we_o    = m0_we_i;
            sram_addr_o  = m0_addr_i[AW+1:2];
            sram_be_o    = m0_be_i;
            sram_wdata_o = m0_wdata_i;
        end else if (gnt[1]) begin
            sram_en_o    = 1'b1;
            sram_we_o    = m1_we_i;
            sram_addr_o  = m1_addr_i[AW+1:2];
            sram_be_o    = m1_be_i;
            sram_wdata_o = m1_wdata_i;
        end
    end

    // Response routing follows the registered tag, not the current grant.
    assign m0_rvalid_o = rsp_vld_q && (rsp_id_q == M0);
    assign m1_rvalid_o = rsp_vld_q && (rsp_id_q == M1);
    assign m0_rdata_o  = (m0_rvalid_o && rsp_rd_q) ? sram_rdata_i : hold0_q;
    assign m1_rdata_o  = (m1_rvalid_o && rsp_rd_q) ? sram_rdata_i : hold1_q;

    always_comb begin
        rsp_vld_d = |gnt;
        rsp_id_d  = gnt[1] ? M1 : M0;
        rsp_rd_d  = gnt[1] ? ~m1_we_i : ~m0_we_i;
        hold0_d   = m0_rdata_o;
        hold1_d   = m1_rdata_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= M0;
            rsp_rd_q  <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_rd_q  <= rsp_rd_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
        end
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a response scoreboard and SRAM macro model.
module tb_sram_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_en, sram_we;
    logic [13:0] sram_addr;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata, sram_q;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] hold[2];
    logic [31:0] mem[0:16383];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    sram_bank_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_i     (m0_req),
        .m0_gnt_o     (m0_gnt),
        .m0_addr_i    (m0_addr),
        .m0_we_i      (m0_we),
        .m0_be_i      (m0_be),
        .m0_wdata_i   (m0_wdata),
        .m0_rvalid_o  (m0_rvalid),
        .m0_rdata_o   (m0_rdata),
        .m1_req_i     (m1_req),
        .m1_gnt_o     (m1_gnt),
        .m1_addr_i    (m1_addr),
        .m1_we_i      (m1_we),
        .m1_be_i      (m1_be),
        .m1_wdata_i   (m1_wdata),
        .m1_rvalid_o  (m1_rvalid),
        .m1_rdata_o   (m1_rdata),
        .sram_en_o    (sram_en),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_be_o    (sram_be),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_q)
    );

    // SRAM macro model: synchronous read, byte-masked write.
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA000_0000 + i;
        mem[64] = 32'h1234_5678;
        sram_q  = '0;
    end

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_q <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_zero_checks();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_be", sram_be, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
    endtask

    // One cycle: check grant/macro outputs at negedge, queue the expected response.
    task automatic check_cycle(input bit eg0, input bit eg1, input logic [31:0] rd0,
                               input logic [31:0] rd1, input bit drop);
        rsp_t e;
        @(negedge clk);
        chk("m0_gnt", m0_gnt, eg0);
        chk("m1_gnt", m1_gnt, eg1);
        if (eg0) begin
            chk("sram_en", sram_en, 1);
            chk("sram_we", sram_we, m0_we);
            chk("sram_addr", sram_addr, m0_addr[15:2]);
            chk("sram_be", sram_be, m0_be);
            chk("sram_wdata", sram_wdata, m0_wdata);
        end else if (eg1) begin
            chk("sram_en", sram_en, 1);
            chk("sram_we", sram_we, m1_we);
            chk("sram_addr", sram_addr, m1_addr[15:2]);
            chk("sram_be", sram_be, m1_be);
            chk("sram_wdata", sram_wdata, m1_wdata);
        end else begin
            chk("idle_sram_en", sram_en, 0);
            chk("idle_sram_bus", {sram_we, sram_addr, sram_be, sram_wdata}, 0);
        end
        if (eg0 && !drop) begin
            e.id   = 1'b0;
            e.data = m0_we ? hold[0] : rd0;
            if (!m0_we) hold[0] = rd0;
            sb.push_back(e);
        end
        if (eg1 && !drop) begin
            e.id   = 1'b1;
            e.data = m1_we ? hold[1] : rd1;
            if (!m1_we) hold[1] = rd1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) begin
                chk("rvalid_onehot", m0_rvalid & m1_rvalid, 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b want none at %0t",
                             m0_rvalid, m1_rvalid, $time);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", m1_rvalid, e.id);
                    chk("rsp_rdata", e.id ? m1_rdata : m0_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
        hold[0] = '0;
        hold[1] = '0;
        repeat (2) begin
            @(negedge clk);
            reset_zero_checks();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // m0 read 0x0010 -> word 4
        m0_req = 1; m0_addr = 16'h0010; m0_be = 4'hF;
        check_cycle(1, 0, 32'hA000_0004, 0, 0);
        m0_req = 0;
        check_cycle(0, 0, 0, 0, 0);

        // m1 partial write to 0x0020 (word 8)
        m1_req = 1; m1_we = 1; m1_be = 4'b0101; m1_wdata = 32'hAABB_CCDD; m1_addr = 16'h0020;
        check_cycle(0, 1, 0, 0, 0);
        m1_req = 0; m1_we = 0;
        check_cycle(0, 0, 0, 0, 0);

        // m0 back-to-back reads: merged word, then neighbour
        m0_req = 1; m0_addr = 16'h0020;
        check_cycle(1, 0, 32'hA0BB_00DD, 0, 0);
        m0_addr = 16'h0024;
        check_cycle(1, 0, 32'hA000_0009, 0, 0);
        m0_req = 0;

        // m1 read with nonzero byte offset: offset ignored
        m1_req = 1; m1_be = 4'hF; m1_addr = 16'h0083;
        check_cycle(0, 1, 0, 32'hA000_0020, 0);

        // Contention for 4 cycles, m1 granted last so m0 first
        m0_req = 1; m0_addr = 16'h0040; m1_addr = 16'h0080;
        check_cycle(1, 0, 32'hA000_0010, 0, 0);
        check_cycle(0, 1, 0, 32'hA000_0020, 0);
        check_cycle(1, 0, 32'hA000_0010, 0, 0);
        check_cycle(0, 1, 0, 32'hA000_0020, 0);
        m0_req = 0; m1_req = 0;
        check_cycle(0, 0, 0, 0, 0);

        // Read 0x12345678 then hold through idle
        m0_req = 1; m0_addr = 16'h0100;
        check_cycle(1, 0, 32'h1234_5678, 0, 0);
        m0_req = 0;
        check_cycle(0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("m0_rdata_hold", m0_rdata, 32'h1234_5678);
            @(posedge clk);
            #1;
        end

        // Write response leaves m0 rdata unchanged
        m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_wdata = 32'hDEAD_BEEF; m0_addr = 16'h0200;
        check_cycle(1, 0, 0, 0, 0);
        m0_req = 0; m0_we = 0;
        check_cycle(0, 0, 0, 0, 0);

        // Reset with a read in flight: response dropped, pointer back to m1-last
        m0_req = 1; m0_addr = 16'h0010;
        check_cycle(1, 0, 32'hA000_0004, 0, 1);
        rst_n = 1'b0;
        m1_req = 1; m1_addr = 16'h0080;
        @(negedge clk);
        reset_zero_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold[0] = '0;
        hold[1] = '0;
        check_cycle(1, 0, 32'hA000_0004, 0, 0);
        check_cycle(0, 1, 0, 32'hA000_0020, 0);
        m0_req = 0; m1_req = 0;
        check_cycle(0, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_bank_arbiter.md
SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

Interface
REQ-001 SHALL have parameter AW, default 14, meaning SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; BW=DW/8 byte enables.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for N in {0,1}, port mN_req_i  input  1  master N access request.
REQ-006 SHALL have port mN_gnt_o  output  1  request accepted this cycle.
REQ-007 SHALL have port mN_addr_i  input  AW+2  byte address.
REQ-008 SHALL have port mN_we_i  input  1  1=write, 0=read.
REQ-009 SHALL have port mN_be_i  input  BW  byte enables.
REQ-010 SHALL have port mN_wdata_i  input  DW  write data.
REQ-011 SHALL have port mN_rvalid_o  output  1  response for previous-cycle grant.
REQ-012 SHALL have port mN_rdata_o  output  DW  read data.
REQ-013 SHALL have ports sram_en_o, sram_we_o  output  1 each  macro enable / write.
REQ-014 SHALL have ports sram_addr_o  output  AW, sram_be_o  output  BW, sram_wdata_o  output  DW  macro address/byte enables/data.
REQ-015 SHALL have port sram_rdata_i  input  DW  macro Q; valid one cycle after read enable.

Function
REQ-016 Grant SHALL be combinational from req in the same cycle; at most one mN_gnt_o high per cycle.
REQ-017 Single requester SHALL be granted immediately, every cycle it requests (back-to-back allowed).
REQ-018 Both requesting SHALL grant the master not granted most recently (2-way round robin); last-grant pointer updates on every grant.
REQ-019 On grant: sram_en_o=1; sram_we_o=granted we_i; sram_addr_o=addr_i[AW+1:2]; sram_be_o=be_i; sram_wdata_o=wdata_i; all zero when no grant.
REQ-020 mN_rvalid_o SHALL pulse exactly one cycle after each grant to N, for reads and writes alike (latency 1).
REQ-021 On read rvalid, mN_rdata_o SHALL equal sram_rdata_i and be captured in a per-master hold register; mN_rdata_o SHALL stay stable until N's next read rvalid.
REQ-022 Write rvalid SHALL NOT change mN_rdata_o.
REQ-023 An ungranted request SHALL remain pending (master holds req/addr/we/be/wdata); no internal queueing.
REQ-024 Grant to one master in cycle t with response to the other in cycle t SHALL both proceed; response routing uses a registered owner/is-read tag, not current grant.
REQ-025 addr_i[1:0] SHALL be ignored; no out-of-range condition exists.

Reset
REQ-026 On rst_n low: gnt, rvalid, sram_en_o, sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o = 0; rdata hold registers = 0; pointer = "m1 last" so m0 wins first contention.
REQ-027 Reset asserted with a read in flight SHALL drop the response; no rvalid after release.
REQ-028 The first grant SHALL be possible in the first clock edge after rst_n rises.

Structure
REQ-029 Package sram_bank_pkg SHALL hold AW/DW/BW defaults and master-id typedef (M0, M1).
REQ-030 Arbitration SHALL be a sub-module rr_arb2 (req[1:0] in, gnt[1:0] out, pointer register inside).
REQ-031 Block SHALL be 120-400 RTL lines; no macro instantiated inside.

Verification
REQ-032 m0 read addr 0x0010 alone -> gnt same cycle, sram_addr_o=0x004, m0_rvalid next cycle with rdata = macro word 4.
REQ-033 m0,m1 both request 4 cycles continuously -> grants m0,m1,m0,m1; rvalids follow one cycle later, each to correct master.
REQ-034 m1 write be=4'b0101 data 0xAABBCCDD addr 0x0020 -> sram_be_o=0101, sram_addr_o=0x008; m1_rvalid next cycle; m1_rdata_o unchanged.
REQ-035 m0 read data 0x12345678, then m0 idle 3 cycles -> m0_rdata_o holds 0x12345678 all 3 cycles.
REQ-036 rst_n asserted cycle after read grant -> no rvalid, all outputs 0, next contention grants m0.
